ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M/RV64M multiply-divide unit alongside the single-cycle execute ALU in the EX stage. It accepts one M-extension operation at a time and computes it one bit per cycle (shift-add multiply, restoring divide). While working it holds the pipeline through a stall request, then presents the result with its destination register to the EX/MEM register for exactly one cycle. Operand width is parametrised, and an optional early-out path shortens trivial operations.

## Interface
Parameters:
- XLEN, 32, operand/result width (32 or 64)
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset; clears state on a rising edge of clk while low
- start_i  in  1  operation request; sampled only in IDLE
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  in  XLEN  operand 1 (multiplicand / dividend)
- rs2_i  in  XLEN  operand 2 (multiplier / divisor)
- wd_i  in  5  destination register address
- flush_i  in  1  abort any in-flight operation
- stallreq_o  out  1  pipeline stall request, combinational
- valid_o  out  1  result valid, one-cycle pulse
- result_o  out  XLEN  result
- wd_o  out  5  destination register of result
- wreg_o  out  1  register write enable; equals valid_o

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if start_i=1 and flush_i=0, latch funct3, wd, operand signs, and operand magnitudes. Go to CALC and load counter=XLEN-1.
- Operand signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Signed operands are converted to absolute value. Unsigned magnitudes are computed, then sign-corrected:
  - product sign = s1 XOR s2
  - quotient sign = s1 XOR s2
  - remainder sign = s1
- Multiply: 2*XLEN-bit accumulator. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the sign-corrected product.
- Divide: restoring division, one quotient bit per cycle.
- Divide boundary cases are required:
  - Divisor 0: quotient all ones regardless of signedness; remainder = rs1 unchanged.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): quotient = -2^(XLEN-1), remainder = 0.
- CALC: one iteration per cycle. When counter reaches 0, go to DONE.
- DONE: valid_o=wreg_o=1, result_o and wd_o driven. Return to IDLE next cycle. start_i in DONE is ignored.
- start_i is ignored in CALC and DONE. Operand inputs after the accept edge have no effect.
- stallreq_o = (IDLE and start_i and !flush_i) or CALC. It is 0 in DONE so the pipeline advances with the result. Forced 0 while rst=0.
- flush_i=1 in any state: next state IDLE, no valid_o pulse, result discarded. In IDLE, flush beats start.
- rst=0: state IDLE, counter 0, valid_o=0, wreg_o=0, result_o=0, wd_o=0; stallreq_o=0. Reset mid-operation discards the operation.
- valid_o, wreg_o, result_o and wd_o are registered. result_o and wd_o hold their last value outside DONE; consumers qualify them with valid_o.

## Timing
- Accept edge = cycle 0; CALC occupies cycles 1..XLEN; DONE (valid_o=1) in cycle XLEN+1.
- Latency from accept edge to valid: XLEN+1 cycles. stallreq_o is high cycles 0..XLEN (XLEN+1 cycles).
- Throughput: one operation per XLEN+2 cycles; the earliest next accept is the IDLE cycle after DONE.
- flush_i asserted in cycle k (1 ≤ k ≤ XLEN+1): IDLE in cycle k+1; a new start_i is accepted in cycle k+1.

## Configuration
- MULDIV_EARLY_OUT_EN defined:
  - In IDLE, if rs1=0 or rs2=0, skip CALC: DONE in cycle 1, stallreq_o high only in cycle 0.
  - Results follow the rules above, including the divide-by-zero values.
- MULDIV_EARLY_OUT_EN undefined: every operation takes the full XLEN+1 cycles; zero-detect logic absent.

## Test plan
- XLEN=32, MUL rs1=7, rs2=0xFFFFFFFD (-3) -> valid_o exactly at cycle 33, result 0xFFFFFFEB, wd_o=wd_i, stallreq_o high cycles 0..32.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 0xFFFFFFF9 / 0 -> 0xFFFFFFFF. REM same -> 0xFFFFFFF9. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0. Repeat the divide-by-zero cases with MULDIV_EARLY_OUT_EN: valid_o at cycle 1.
- Flush at cycle 10 of DIVU -> no valid_o pulse, IDLE at cycle 11. New MUL 3×4 started at cycle 11 -> 12 at cycle 44. start_i and flush_i together in IDLE -> not accepted.
- rst low at cycle 5 of MUL, released later -> all outputs 0, no valid_o. XLEN=64 instance: MULHU 2^63×4 -> 2, valid at cycle 65.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: operations with a zero operand skip straight to DONE.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      wd_i,
  input  logic            flush_i,
  output logic            stallreq_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          wd_q, wd_d;
  logic                neg1_q, neg1_d, neg2_q, neg2_d, dz_q, dz_d;
  logic [XLEN-1:0]     rs1_q, rs1_d, opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [4:0]          wdo_q, wdo_d;
  logic                valid_q, valid_d;

  logic                sgn1_s, sgn2_s, neg1_s, neg2_s;
  logic [XLEN-1:0]     mag1_s, mag2_s, mul_add_s;
  logic [XLEN:0]       mul_sum_s, div_diff_s;
  logic [2*XLEN-1:0]   acc_next_s;

  // Magnitudes come out unsigned; the recorded operand signs fix up the final value.
  function automatic logic [XLEN-1:0] finish_res(input logic [2:0] f3, input logic [2*XLEN-1:0] acc,
                                                 input logic n1, input logic n2, input logic dz,
                                                 input logic [XLEN-1:0] rs1v);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;
    prod = (n1 ^ n2) ? -acc : acc;
    quo  = (n1 ^ n2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = n1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3)
      3'b000:                 res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = dz ? {XLEN{1'b1}} : quo;
      3'b110, 3'b111:         res = dz ? rs1v : rem;
      default:                res = '0;
    endcase
    return res;
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  function automatic logic [XLEN-1:0] early_res(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    if (!f3[2]) begin
      res = '0;
    end else if (b == '0) begin
      res = f3[1] ? a : {XLEN{1'b1}};
    end else begin
      res = '0;
    end
    return res;
  endfunction
`endif

  assign sgn1_s = (funct3_i != 3'b011) && (funct3_i != 3'b101) && (funct3_i != 3'b111);
  assign sgn2_s = sgn1_s && (funct3_i != 3'b010);
  assign neg1_s = sgn1_s & rs1_i[XLEN-1];
  assign neg2_s = sgn2_s & rs2_i[XLEN-1];
  assign mag1_s = neg1_s ? -rs1_i : rs1_i;
  assign mag2_s = neg2_s ? -rs2_i : rs2_i;

  // Datapath step: low accumulator half holds the multiplier (mul) or dividend/quotient (div).
  assign mul_add_s  = acc_q[0] ? opnd_q : '0;
  assign mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add_s};
  assign div_diff_s = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
  assign acc_next_s = f3_q[2] ? (div_diff_s[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                                  : {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                              : {mul_sum_s, acc_q[XLEN-1:1]};

  assign stallreq_o = rst && (((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC));
  assign valid_o    = valid_q;
  assign wreg_o     = valid_q;
  assign result_o   = res_q;
  assign wd_o       = wdo_q;

  // Next-state, operand capture and result formation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    wd_d    = wd_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    dz_d    = dz_q;
    rs1_d   = rs1_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    wdo_d   = wdo_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          f3_d   = funct3_i;
          wd_d   = wd_i;
          neg1_d = neg1_s;
          neg2_d = neg2_s;
          dz_d   = (rs2_i == '0);
          rs1_d  = rs1_i;
          if (funct3_i[2]) begin
            opnd_d = mag2_s;
            acc_d  = {{XLEN{1'b0}}, mag1_s};
          end else begin
            opnd_d = mag1_s;
            acc_d  = {{XLEN{1'b0}}, mag2_s};
          end
`ifdef MULDIV_EARLY_OUT_EN
          if ((rs1_i == '0) || (rs2_i == '0)) begin
            state_d = DONE;
            cnt_d   = '0;
            valid_d = 1'b1;
            res_d   = early_res(funct3_i, rs1_i, rs2_i);
            wdo_d   = wd_i;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_INIT;
          end
`else
          state_d = CALC;
          cnt_d   = CNT_INIT;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_next_s;
        if (cnt_q == '0) begin
          state_d = DONE;
          valid_d = 1'b1;
          res_d   = finish_res(f3_q, acc_next_s, neg1_q, neg2_q, dz_q, rs1_q);
          wdo_d   = wd_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      res_d   = res_q;
      wdo_d   = wdo_q;
    end else begin
      valid_d = valid_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= 3'b000;
      wd_q    <= 5'd0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      dz_q    <= 1'b0;
      rs1_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      wdo_q   <= 5'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      wd_q    <= wd_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      dz_q    <= dz_d;
      rs1_q   <= rs1_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      wdo_q   <= wdo_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed boundary cases, randomized ops against an arithmetic model,
// flush/reset behaviour, and a 64-bit instance.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  wd_i;
  logic        stallreq_o, valid_o, wreg_o;
  logic [31:0] result_o;
  logic [4:0]  wd_o;

  logic        start64;
  logic [2:0]  f3_64;
  logic [63:0] rs1_64, rs2_64;
  logic        stall64, valid64, wreg64;
  logic [63:0] result64;
  logic [4:0]  wd_o64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .wd_i(wd_i), .flush_i(flush_i), .stallreq_o(stallreq_o), .valid_o(valid_o),
    .result_o(result_o), .wd_o(wd_o), .wreg_o(wreg_o)
  );

  ex_muldiv #(.XLEN(64), .CNT_W(7)) dut64 (
    .clk(clk), .rst(rst), .start_i(start64), .funct3_i(f3_64), .rs1_i(rs1_64), .rs2_i(rs2_64),
    .wd_i(5'd9), .flush_i(flush_i), .stallreq_o(stall64), .valid_o(valid64),
    .result_o(result64), .wd_o(wd_o64), .wreg_o(wreg64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: widen to 64 bits with the operation's signedness and use plain arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    int sa, sb;
    x  = (f3 == 3'b011) ? {32'd0, a} : {{32{a[31]}}, a};
    y  = (f3 == 3'b010 || f3 == 3'b011) ? {32'd0, b} : {{32{b[31]}}, b};
    p  = x * y;
    sa = a;
    sb = b;
    case (f3)
      3'b000: return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        else return 32'(sa / sb);
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else return a / b;
      end
      3'b110: begin
        if (b == 32'd0) return a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        else return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        else return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Starts at a negedge (cycle 0), returns at the negedge of the IDLE cycle after DONE.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic [31:0] exp_res);
    int cyc = 1;
    int lat;
    bit got = 1'b0;
    bit stall_bad = 1'b0;
    lat = exp_lat(a, b);
    funct3_i = f3; rs1_i = a; rs2_i = b; wd_i = wd; start_i = 1'b1;
    #1;
    chk({tag, "_stall_c0"}, {63'd0, stallreq_o}, 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    rs1_i = $urandom; rs2_i = $urandom; wd_i = 5'($urandom);
    while (!got && cyc <= lat + 5) begin
      if (valid_o) begin
        got = 1'b1;
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        chk({tag, "_res"}, {32'd0, result_o}, {32'd0, exp_res});
        chk({tag, "_wd"}, {59'd0, wd_o}, {59'd0, wd});
        chk({tag, "_wreg"}, {63'd0, wreg_o}, 64'd1);
        chk({tag, "_stall_done"}, {63'd0, stallreq_o}, 64'd0);
      end else begin
        if (stallreq_o !== 1'b1) stall_bad = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_seen"}, {63'd0, got}, 64'd1);
    chk({tag, "_stall_busy"}, {63'd0, stall_bad}, 64'd0);
    chk({tag, "_pulse"}, {63'd0, valid_o}, 64'd0);
    chk({tag, "_hold"}, {32'd0, result_o}, {32'd0, exp_res});
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          cyc;
    bit          seen;
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; funct3_i = 3'b000;
    rs1_i = 32'd0; rs2_i = 32'd0; wd_i = 5'd0;
    start64 = 1'b0; f3_64 = 3'b000; rs1_64 = 64'd0; rs2_64 = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_wreg", {63'd0, wreg_o}, 64'd0);
    chk("rst_res", {32'd0, result_o}, 64'd0);
    chk("rst_wd", {59'd0, wd_o}, 64'd0);

    do_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF);
    do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE);
    do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD);
    do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF);
    do_op("divu",   3'b101, 32'd100,       32'd7,         5'd11, 32'd14);
    do_op("remu",   3'b111, 32'd100,       32'd7,         5'd12, 32'd2);
    do_op("div0",   3'b100, 32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFFF);
    do_op("rem0",   3'b110, 32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFF9);
    do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0);

    for (int i = 0; i < 20; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: a = a;
      endcase
      do_op("rand", f3, a, b, 5'($urandom), ref_op(f3, a, b));
    end

    // Flush in cycle 10 of a DIVU, then MUL accepted in cycle 11.
    funct3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7; wd_i = 5'd3; start_i = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (valid_o) seen = 1'b1;
      if (c == 10) flush_i = 1'b1;
      @(negedge clk);
    end
    flush_i = 1'b0;
    if (valid_o) seen = 1'b1;
    chk("flush_novalid", {63'd0, seen}, 64'd0);
    chk("flush_idle", {63'd0, stallreq_o}, 64'd0);
    do_op("after_flush", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12);

    // start together with flush in IDLE is not accepted.
    funct3_i = 3'b000; rs1_i = 32'd5; rs2_i = 32'd6; start_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("sf_stall", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o || stallreq_o) seen = 1'b1;
      @(negedge clk);
    end
    chk("sf_noaccept", {63'd0, seen}, 64'd0);

    // Reset in cycle 5 of a MUL.
    funct3_i = 3'b000; rs1_i = 32'd9; rs2_i = 32'd9; wd_i = 5'd30; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_stall", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    chk("rstmid_valid", {63'd0, valid_o}, 64'd0);
    chk("rstmid_res", {32'd0, result_o}, 64'd0);
    chk("rstmid_wd", {59'd0, wd_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o || stallreq_o) seen = 1'b1;
      @(negedge clk);
    end
    chk("rstmid_discard", {63'd0, seen}, 64'd0);
    chk("rstmid_res2", {32'd0, result_o}, 64'd0);

    // 64-bit MULHU 2^63 x 4.
    f3_64 = 3'b011; rs1_64 = 64'h8000_0000_0000_0000; rs2_64 = 64'd4; start64 = 1'b1;
    #1;
    chk("m64_stall", {63'd0, stall64}, 64'd1);
    @(negedge clk);
    start64 = 1'b0;
    cyc = 1;
    while (!valid64 && cyc <= 80) begin
      @(negedge clk);
      cyc++;
    end
    chk("m64_lat", 64'(cyc), 64'd65);
    chk("m64_res", result64, 64'd2);
    chk("m64_wd", {59'd0, wd_o64}, 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
